serial_subtractor: RTL and testbench

//  Parametrised multi-cycle N-bit subtractor; successor to the single-bit full subtractor.

---
 rtl/serial_subtractor.sv | 106 ++++++++++
 tb/tb_serial_subtractor.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Multi-cycle N-bit subtractor: minuend - subtrahend - borrow_in, DIGIT bits per clock (optional SERIAL_SUB_OVF_EN adds overflow).
// Latency: done pulses in the cycle after the STEPS-th RUN edge following the accepting edge.
// Backpressure: start is taken only when idle; start while busy is dropped, operands are not re-latched.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             borrow_q;
    logic [DIGIT:0]   dsub;
    logic [WIDTH-1:0] diff_nxt;

    // One digit of the full-subtractor chain; the top bit is the outgoing borrow.
    assign dsub = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow_q};

    // Result digits enter from the MSB side so the first digit ends up in the LSBs.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign diff_nxt = dsub[DIGIT-1:0];
        end else begin : g_shift
            assign diff_nxt = {dsub[DIGIT-1:0], diff[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign busy = (state == RUN);

`ifdef SERIAL_SUB_OVF_EN
    logic sign_a;
    logic sign_b;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            borrow_q   <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            done       <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            overflow   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_q      <= minuend;
                    b_q      <= subtrahend;
                    borrow_q <= borrow_in;
                    count    <= '0;
                    state    <= RUN;
`ifdef SERIAL_SUB_OVF_EN
                    sign_a   <= minuend[WIDTH-1];
                    sign_b   <= subtrahend[WIDTH-1];
                    overflow <= 1'b0;
`endif
                end
            end else begin
                a_q      <= a_q >> DIGIT;
                b_q      <= b_q >> DIGIT;
                borrow_q <= dsub[DIGIT];
                diff     <= diff_nxt;
                count    <= count + CW'(1);
                if (count == LAST) begin
                    state      <= IDLE;
                    done       <= 1'b1;
                    borrow_out <= dsub[DIGIT];
`ifdef SERIAL_SUB_OVF_EN
                    overflow   <= (sign_a != sign_b) && (diff_nxt[WIDTH-1] != sign_a);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: four configurations (8/1, 8/4, 8/8, 4/1) against an arithmetic A-B-bin model.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Instance index: 0 = W8/D1, 1 = W8/D4, 2 = W8/D8, 3 = W4/D1
    int steps [4] = '{8, 2, 1, 4};
    int width [4] = '{8, 8, 8, 4};

    logic       st     [4];
    logic [7:0] a_in   [4];
    logic [7:0] b_in   [4];
    logic       bin_in [4];

    logic       o_busy [4];
    logic       o_done [4];
    logic [7:0] o_diff [4];
    logic       o_bo   [4];

    logic [7:0] d81, d84, d88;
    logic [3:0] d41;
    assign o_diff[0] = d81;
    assign o_diff[1] = d84;
    assign o_diff[2] = d88;
    assign o_diff[3] = {4'b0, d41};

`ifdef SERIAL_SUB_OVF_EN
    logic o_ov [4];
`endif

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u81 (
        .clk(clk), .rst(rst), .start(st[0]), .minuend(a_in[0]), .subtrahend(b_in[0]),
        .borrow_in(bin_in[0]), .busy(o_busy[0]), .done(o_done[0]), .diff(d81), .borrow_out(o_bo[0])
`ifdef SERIAL_SUB_OVF_EN
        , .overflow(o_ov[0])
`endif
    );
    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u84 (
        .clk(clk), .rst(rst), .start(st[1]), .minuend(a_in[1]), .subtrahend(b_in[1]),
        .borrow_in(bin_in[1]), .busy(o_busy[1]), .done(o_done[1]), .diff(d84), .borrow_out(o_bo[1])
`ifdef SERIAL_SUB_OVF_EN
        , .overflow(o_ov[1])
`endif
    );
    serial_subtractor #(.WIDTH(8), .DIGIT(8)) u88 (
        .clk(clk), .rst(rst), .start(st[2]), .minuend(a_in[2]), .subtrahend(b_in[2]),
        .borrow_in(bin_in[2]), .busy(o_busy[2]), .done(o_done[2]), .diff(d88), .borrow_out(o_bo[2])
`ifdef SERIAL_SUB_OVF_EN
        , .overflow(o_ov[2])
`endif
    );
    serial_subtractor #(.WIDTH(4), .DIGIT(1)) u41 (
        .clk(clk), .rst(rst), .start(st[3]), .minuend(a_in[3][3:0]), .subtrahend(b_in[3][3:0]),
        .borrow_in(bin_in[3]), .busy(o_busy[3]), .done(o_done[3]), .diff(d41), .borrow_out(o_bo[3])
`ifdef SERIAL_SUB_OVF_EN
        , .overflow(o_ov[3])
`endif
    );

    typedef struct {
        int         id;
        int         k;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } exp_t;

    exp_t       q [$];
    logic [7:0] last_d  [4];
    logic       last_bo [4];
    logic       last_ov [4];
    int         last_k  [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        q.delete();
        for (int i = 0; i < 4; i++) begin
            last_d[i]  = 8'h00;
            last_bo[i] = 1'b0;
            last_ov[i] = 1'b0;
        end
    endtask

    // Drives start at posedge+1; the following edge accepts. Model computed with plain integer arithmetic.
    task automatic issue(input int id, input int a, input int b, input int bin);
        exp_t e;
        int   w, mask, ai, bi, r, dv;
        w    = width[id];
        mask = (1 << w) - 1;
        ai   = a & mask;
        bi   = b & mask;
        r    = ai - bi - bin;
        dv   = r & mask;
        e.id = id;
        e.k  = cyc + 1;
        e.d  = 8'(dv);
        e.bo = (r < 0);
        e.ov = ((((ai >> (w - 1)) & 1) != ((bi >> (w - 1)) & 1)) &&
                (((dv >> (w - 1)) & 1) != ((ai >> (w - 1)) & 1)));
        q.push_back(e);
        last_k[id] = e.k;
        a_in[id]   = 8'(a);
        b_in[id]   = 8'(b);
        bin_in[id] = bin[0];
        st[id]     = 1'b1;
        step();
        st[id]     = 1'b0;
        a_in[id]   = 8'($urandom);
        b_in[id]   = 8'($urandom);
        bin_in[id] = 1'($urandom);
    endtask

    // Returns inside the done cycle (posedge+1) so a following issue() lands in that cycle.
    task automatic wait_done(input int id, input int lat, input string nm);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 64; n++) begin
            if (o_done[id]) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk({nm, "_latency"}, found ? 64'(cyc - last_k[id]) : 64'hFFFF, 64'(lat));
    endtask

    int   idx;
    bit   e_busy, e_done, active;

    always @(negedge clk) begin
        if (!rst) begin
            for (int id = 0; id < 4; id++) begin
                e_busy = 1'b0;
                e_done = 1'b0;
                active = 1'b0;
                idx    = -1;
                foreach (q[i]) begin
                    if (q[i].id == id) begin
                        if (q[i].k <= cyc) active = 1'b1;
                        if (cyc >= q[i].k && cyc < q[i].k + steps[id]) e_busy = 1'b1;
                        if (cyc == q[i].k + steps[id]) begin
                            e_done = 1'b1;
                            idx    = i;
                        end
                    end
                end
                chk($sformatf("busy[%0d]", id), 64'(o_busy[id]), 64'(e_busy));
                chk($sformatf("done[%0d]", id), 64'(o_done[id]), 64'(e_done));
                if (idx >= 0) begin
                    chk($sformatf("diff[%0d]", id), 64'(o_diff[id]), 64'(q[idx].d));
                    chk($sformatf("borrow_out[%0d]", id), 64'(o_bo[id]), 64'(q[idx].bo));
`ifdef SERIAL_SUB_OVF_EN
                    chk($sformatf("overflow[%0d]", id), 64'(o_ov[id]), 64'(q[idx].ov));
`endif
                    last_d[id]  = q[idx].d;
                    last_bo[id] = q[idx].bo;
                    last_ov[id] = q[idx].ov;
                    q.delete(idx);
                end else if (!active) begin
                    chk($sformatf("diff_hold[%0d]", id), 64'(o_diff[id]), 64'(last_d[id]));
                    chk($sformatf("borrow_hold[%0d]", id), 64'(o_bo[id]), 64'(last_bo[id]));
`ifdef SERIAL_SUB_OVF_EN
                    chk($sformatf("overflow_hold[%0d]", id), 64'(o_ov[id]), 64'(last_ov[id]));
`endif
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            st[i] = 1'b0; a_in[i] = 8'h00; b_in[i] = 8'h00; bin_in[i] = 1'b0;
        end
        clear_model();
        rst = 1'b1;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_busy[%0d]", i), 64'(o_busy[i]), 64'd0);
            chk($sformatf("reset_done[%0d]", i), 64'(o_done[i]), 64'd0);
            chk($sformatf("reset_diff[%0d]", i), 64'(o_diff[i]), 64'd0);
            chk($sformatf("reset_bo[%0d]", i), 64'(o_bo[i]), 64'd0);
        end
        rst = 1'b0;
        step();

        // Basic W8/D1 cases
        issue(0, 8'h05, 8'h03, 0); wait_done(0, 8, "t1");
        chk("t1_diff", 64'(o_diff[0]), 64'h02); chk("t1_bo", 64'(o_bo[0]), 64'd0);
        step();
        issue(0, 8'h03, 8'h05, 0); wait_done(0, 8, "t2a");
        chk("t2a_diff", 64'(o_diff[0]), 64'hFE); chk("t2a_bo", 64'(o_bo[0]), 64'd1);
        step();
        issue(0, 8'h00, 8'h00, 1); wait_done(0, 8, "t2b");
        chk("t2b_diff", 64'(o_diff[0]), 64'hFF); chk("t2b_bo", 64'(o_bo[0]), 64'd1);
        step();

        // D=4 with back-to-back start in the done cycle, then D=8
        issue(1, 8'hA7, 8'h58, 1); wait_done(1, 2, "t3a");
        chk("t3a_diff", 64'(o_diff[1]), 64'h4E); chk("t3a_bo", 64'(o_bo[1]), 64'd0);
        issue(1, 8'h12, 8'h34, 0); wait_done(1, 2, "t3b");
        chk("t3b_diff", 64'(o_diff[1]), 64'hDE); chk("t3b_bo", 64'(o_bo[1]), 64'd1);
        step();
        issue(2, 8'h10, 8'h01, 1); wait_done(2, 1, "t3c");
        chk("t3c_diff", 64'(o_diff[2]), 64'h0E); chk("t3c_bo", 64'(o_bo[2]), 64'd0);
        issue(2, 8'h00, 8'h01, 0); wait_done(2, 1, "t3d");
        chk("t3d_diff", 64'(o_diff[2]), 64'hFF); chk("t3d_bo", 64'(o_bo[2]), 64'd1);
        step();

        // Start mid-RUN with new operands must be dropped
        issue(0, 8'h05, 8'h03, 0);
        step();
        a_in[0] = 8'hFF; b_in[0] = 8'h00; bin_in[0] = 1'b1; st[0] = 1'b1;
        step();
        st[0] = 1'b0;
        wait_done(0, 8, "t4");
        chk("t4_diff", 64'(o_diff[0]), 64'h02); chk("t4_bo", 64'(o_bo[0]), 64'd0);
        step();

        // Reset during RUN cycle 3, with start held during reset
        issue(0, 8'hAA, 8'h11, 0);
        step();
        step();
        rst = 1'b1;
        a_in[0] = 8'h55; b_in[0] = 8'h01; st[0] = 1'b1;
        clear_model();
        #1;
        chk("t5_busy", 64'(o_busy[0]), 64'd0);
        chk("t5_diff", 64'(o_diff[0]), 64'd0);
        chk("t5_done", 64'(o_done[0]), 64'd0);
        step();
        st[0] = 1'b0;
        rst = 1'b0;
        step();
        step();
        chk("t5_idle_after", 64'(o_busy[0]), 64'd0);
        issue(0, 8'h40, 8'h41, 0); wait_done(0, 8, "t5b");
        chk("t5b_diff", 64'(o_diff[0]), 64'hFF); chk("t5b_bo", 64'(o_bo[0]), 64'd1);
        step();

        // Signed-overflow corner cases
        issue(0, 8'h80, 8'h01, 0); wait_done(0, 8, "t6a");
        chk("t6a_diff", 64'(o_diff[0]), 64'h7F); chk("t6a_bo", 64'(o_bo[0]), 64'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("t6a_ovf", 64'(o_ov[0]), 64'd1);
`endif
        step();
        issue(0, 8'h7F, 8'hFF, 0); wait_done(0, 8, "t6b");
        chk("t6b_diff", 64'(o_diff[0]), 64'h80); chk("t6b_bo", 64'(o_bo[0]), 64'd1);
`ifdef SERIAL_SUB_OVF_EN
        chk("t6b_ovf", 64'(o_ov[0]), 64'd1);
`endif
        step();
        issue(0, 8'h05, 8'h03, 0); wait_done(0, 8, "t6c");
`ifdef SERIAL_SUB_OVF_EN
        chk("t6c_ovf", 64'(o_ov[0]), 64'd0);
`endif
        step();

        // Exhaustive W4/D1, issued back-to-back in each done cycle
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    issue(3, a, b, c);
                    wait_done(3, 4, "t6x");
                end
        step();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
